menu_mode_ctrl: RTL and testbench
=================================

Name: menu_mode_ctrl

Overview:
- Parametrised main-menu control path for the human-benchmark game.
- Selects one of NUM_GAMES game modes from a user choice and a press/release on the mode button.
- Issues a one-cycle start strobe and holds one-hot game enables until the game reports done or the user long-presses quit.
- Sits between the button/switch inputs and the per-game datapaths and screen loaders.

Parameters:
- NUM_GAMES, 2: number of selectable games. Choice k (1..NUM_GAMES) enables oGameEn[k-1]. Constraint: NUM_GAMES <= 2^SEL_W - 1.
- SEL_W, 2: width of iUserChoice.
- QUIT_HOLD, 4: consecutive cycles iQuit must be high in RUN to abort. Must be >= 1.

Ports:
- iClock  in  1  system clock, all state on rising edge
- iResetn  in  1  asynchronous active-low reset
- iMode  in  1  mode/confirm button, level
- iQuit  in  1  quit button, level
- iUserChoice  in  SEL_W  requested game; 0 means menu
- iGameDone  in  1  one-cycle done strobe from the active game
- oMenu  out  1  menu screen active
- oGameEn  out  NUM_GAMES  one-hot enable of the running game
- oStart  out  1  one-cycle strobe on game entry
- oReject  out  1  one-cycle strobe on an invalid selection
- oActiveGame  out  SEL_W  latched choice of the current or last game

Behaviour:
- Reset: iResetn=0 asynchronously forces the following, regardless of state mid-game:
  - state=MENU, choice register=0, quit counter=0
  - oMenu=1, oGameEn=0, oStart=0, oReject=0, oActiveGame=0
- Outputs are Moore: decoded from registered state and the choice register only, never combinationally from inputs.
- States:
  - MENU: oMenu=1.
    - iMode=1 and 1<=iUserChoice<=NUM_GAMES: latch iUserChoice into the choice register, go to ARM.
    - iMode=1 and choice invalid (0 or >NUM_GAMES): go to REJECT.
    - Otherwise stay.
  - REJECT: oMenu=1, oReject=1 for exactly this one state-cycle. Then go to REJ_WAIT.
  - REJ_WAIT: oMenu=1. Stay while iMode=1; iMode=0 returns to MENU.
  - ARM: oMenu=1. Stay while iMode=1; iMode=0 goes to LOAD. The game starts on button release, not on press. iUserChoice changes in ARM are ignored (the choice is already latched).
  - LOAD: oMenu=0, oGameEn=onehot(choice-1), oStart=1. Lasts one cycle, then go to RUN.
  - RUN: oGameEn held, oStart=0.
    - iMode is ignored.
    - Quit counter increments each cycle iQuit=1 and clears to 0 on any cycle iQuit=0.
    - Counter reaching QUIT_HOLD-1 while iQuit=1 goes to QUIT_WAIT (quit recognised on the QUIT_HOLD-th consecutive high cycle).
    - iGameDone=1 goes to MENU and has priority over quit in the same cycle.
    - The counter clears on exit from RUN.
  - QUIT_WAIT: oMenu=1, oGameEn=0. Stay while iQuit=1; iQuit=0 returns to MENU. The held quit button therefore cannot re-trigger anything.
- Latency: from the edge that samples iMode=0 in ARM, oStart and oGameEn are high on the following cycle.
- iGameDone and iQuit in MENU, ARM, REJECT, REJ_WAIT or LOAD are ignored.
- oActiveGame = choice register. It is updated only on the MENU->ARM transition and retained through the return to menu.
- oGameEn is never non-zero in the same cycle as oMenu=1. At most one bit of oGameEn is ever set.
- Quit counter width: clog2(QUIT_HOLD)+1 bits. The counter saturates, so it never wraps.
- Illegal or unreachable state encodings go to MENU on the next edge.

Test Plan:
1. Reset release, iUserChoice=2, iMode held high for 3 cycles then low:
   - oMenu=1 throughout the press.
   - One cycle after release: oStart=1 for exactly 1 cycle, oGameEn=2'b10, oActiveGame=2.
2. In RUN with QUIT_HOLD=4:
   - iQuit high for 3 cycles, low 1, high 4: no quit after the first burst.
   - Quit occurs on the 4th high cycle of the second burst: oGameEn=0, oMenu=1.
   - iQuit held 5 more cycles stays in QUIT_WAIT; release gives MENU.
3. iUserChoice=0 with iMode pressed: oReject=1 for one cycle, oGameEn stays 0, oActiveGame unchanged. iUserChoice=3 with NUM_GAMES=2 behaves the same.
4. In RUN, iGameDone=1 and iQuit high for its QUIT_HOLD-th cycle in the same cycle:
   - Next state is MENU, not QUIT_WAIT.
   - A subsequent iQuit pulse in MENU has no effect.
5. iResetn driven low asynchronously mid-RUN (between clock edges):
   - Immediately oGameEn=0, oMenu=1, oActiveGame=0.
   - After release, a new select of game 1 gives oGameEn=2'b01.
6. Re-parametrise NUM_GAMES=5, SEL_W=3, choice=5 → oGameEn=5'b10000. Changing iUserChoice during ARM has no effect on the latched choice.

Source files
------------

// File: rtl/menu_mode_ctrl.sv
// Main-menu control path: picks a game from the user's choice on mode-button
// release, strobes its start, and holds its enable until done or a long quit press.
module menu_mode_ctrl #(
    parameter int NUM_GAMES = 2,
    parameter int SEL_W     = 2,
    parameter int QUIT_HOLD = 4
) (
    input  logic                 iClock,
    input  logic                 iResetn,
    input  logic                 iMode,
    input  logic                 iQuit,
    input  logic [SEL_W-1:0]     iUserChoice,
    input  logic                 iGameDone,
    output logic                 oMenu,
    output logic [NUM_GAMES-1:0] oGameEn,
    output logic                 oStart,
    output logic                 oReject,
    output logic [SEL_W-1:0]     oActiveGame,
    output logic [2:0]           oDbgState
);

    localparam int CW = $clog2(QUIT_HOLD) + 1;

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_REJECT    = 3'd1,
        S_REJ_WAIT  = 3'd2,
        S_ARM       = 3'd3,
        S_LOAD      = 3'd4,
        S_RUN       = 3'd5,
        S_QUIT_WAIT = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       choice_q, choice_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   menu_d, start_d, reject_d;
    logic [NUM_GAMES-1:0]   en_d;
    logic                   choice_ok;

    assign choice_ok = (iUserChoice != '0) && (iUserChoice <= SEL_W'(NUM_GAMES));

    always_comb begin
        state_d  = state_q;
        choice_d = choice_q;
        cnt_d    = '0;
        case (state_q)
            S_MENU: begin
                if (iMode && choice_ok) begin
                    choice_d = iUserChoice;
                    state_d  = S_ARM;
                end else if (iMode) begin
                    state_d = S_REJECT;
                end
            end
            S_REJECT:    state_d = S_REJ_WAIT;
            S_REJ_WAIT:  if (!iMode) state_d = S_MENU;
            S_ARM:       if (!iMode) state_d = S_LOAD;
            S_LOAD:      state_d = S_RUN;
            S_RUN: begin
                // Done wins over a quit that completes in the same cycle.
                if (iGameDone) begin
                    state_d = S_MENU;
                end else if (iQuit) begin
                    if (cnt_q == CW'(QUIT_HOLD - 1)) begin
                        state_d = S_QUIT_WAIT;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            S_QUIT_WAIT: if (!iQuit) state_d = S_MENU;
            default:     state_d = S_MENU;
        endcase
    end

    // Outputs are registered alongside the state they decode, so they stay Moore.
    always_comb begin
        menu_d   = !((state_d == S_LOAD) || (state_d == S_RUN));
        start_d  = (state_d == S_LOAD);
        reject_d = (state_d == S_REJECT);
        en_d     = '0;
        if (!menu_d) begin
            for (int i = 0; i < NUM_GAMES; i++) begin
                en_d[i] = (choice_d == SEL_W'(i + 1));
            end
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q  <= S_MENU;
            choice_q <= '0;
            cnt_q    <= '0;
            oMenu    <= 1'b1;
            oGameEn  <= '0;
            oStart   <= 1'b0;
            oReject  <= 1'b0;
        end else begin
            state_q  <= state_d;
            choice_q <= choice_d;
            cnt_q    <= cnt_d;
            oMenu    <= menu_d;
            oGameEn  <= en_d;
            oStart   <= start_d;
            oReject  <= reject_d;
        end
    end

    assign oActiveGame = choice_q;
    assign oDbgState   = state_q;

endmodule

// File: tb/tb_menu_mode_ctrl.sv
// Directed bench for menu_mode_ctrl: default 2-game instance plus a 5-game instance.
module tb_menu_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0, quit = 1'b0, done = 1'b0;
    logic [1:0] choice = '0;
    logic       menu, start, reject;
    logic [1:0] en, active;
    logic [2:0] dbg;

    logic       mode5 = 1'b0, quit5 = 1'b0, done5 = 1'b0;
    logic [2:0] choice5 = '0;
    logic       menu5, start5, reject5;
    logic [4:0] en5;
    logic [2:0] active5, dbg5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    menu_mode_ctrl dut (
        .iClock(clk), .iResetn(rst_n), .iMode(mode), .iQuit(quit),
        .iUserChoice(choice), .iGameDone(done), .oMenu(menu), .oGameEn(en),
        .oStart(start), .oReject(reject), .oActiveGame(active), .oDbgState(dbg)
    );

    menu_mode_ctrl #(.NUM_GAMES(5), .SEL_W(3), .QUIT_HOLD(4)) dut5 (
        .iClock(clk), .iResetn(rst_n), .iMode(mode5), .iQuit(quit5),
        .iUserChoice(choice5), .iGameDone(done5), .oMenu(menu5), .oGameEn(en5),
        .oStart(start5), .oReject(reject5), .oActiveGame(active5), .oDbgState(dbg5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (menu !== 1'b1) begin errors++; $display("FAIL reset_menu: got %0b want 1", menu); end
        checks++; if (en !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", en); end
        checks++; if ({start, reject} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {start, reject}); end
        checks++; if (active !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d want 0", active); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_select();
        choice = 2'd2; mode = 1'b1;
        tick();
        checks++; if (menu !== 1'b1 || active !== 2'd2) begin errors++; $display("FAIL sel_arm: menu=%0b active=%0d want 1/2", menu, active); end
        tick(); tick();
        checks++; if (menu !== 1'b1 || en !== 2'b00 || start !== 1'b0) begin errors++; $display("FAIL sel_hold: menu=%0b en=%b start=%0b want 1/00/0", menu, en, start); end
        mode = 1'b0;
        tick();
        checks++; if (start !== 1'b1 || en !== 2'b10 || menu !== 1'b0) begin errors++; $display("FAIL sel_load: start=%0b en=%b menu=%0b want 1/10/0", start, en, menu); end
        checks++; if (active !== 2'd2) begin errors++; $display("FAIL sel_active: got %0d want 2", active); end
        tick();
        checks++; if (start !== 1'b0 || en !== 2'b10) begin errors++; $display("FAIL sel_run: start=%0b en=%b want 0/10", start, en); end
    endtask

    task automatic test_quit();
        quit = 1'b1; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (en !== 2'b10 || menu !== 1'b0) begin errors++; $display("FAIL quit_burst1_%0d: en=%b menu=%0b want 10/0", i, en, menu); end
        end
        quit = 1'b0; mode = 1'b0;
        tick();
        quit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (en !== 2'b10) begin errors++; $display("FAIL quit_burst2_%0d: en=%b want 10", i, en); end
        end
        tick();
        checks++; if (en !== 2'b00 || menu !== 1'b1) begin errors++; $display("FAIL quit_hit: en=%b menu=%0b want 00/1", en, menu); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (dbg !== 3'd6 || en !== 2'b00 || menu !== 1'b1) begin errors++; $display("FAIL quit_wait: state=%0d en=%b menu=%0b want 6/00/1", dbg, en, menu); end
        quit = 1'b0;
        tick();
        checks++; if (dbg !== 3'd0 || active !== 2'd2) begin errors++; $display("FAIL quit_release: state=%0d active=%0d want 0/2", dbg, active); end
    endtask

    task automatic test_reject();
        choice = 2'd0; mode = 1'b1;
        tick();
        checks++; if (reject !== 1'b1 || menu !== 1'b1 || en !== 2'b00 || active !== 2'd2) begin errors++; $display("FAIL rej0: rej=%0b menu=%0b en=%b active=%0d want 1/1/00/2", reject, menu, en, active); end
        tick();
        checks++; if (reject !== 1'b0 || dbg !== 3'd2) begin errors++; $display("FAIL rej0_wait: rej=%0b state=%0d want 0/2", reject, dbg); end
        mode = 1'b0;
        tick();
        checks++; if (dbg !== 3'd0) begin errors++; $display("FAIL rej0_menu: state=%0d want 0", dbg); end
        choice = 2'd3; mode = 1'b1;
        tick();
        checks++; if (reject !== 1'b1 || en !== 2'b00 || active !== 2'd2) begin errors++; $display("FAIL rej3: rej=%0b en=%b active=%0d want 1/00/2", reject, en, active); end
        mode = 1'b0;
        tick();
        checks++; if (reject !== 1'b0 || dbg !== 3'd2) begin errors++; $display("FAIL rej3_wait: rej=%0b state=%0d want 0/2", reject, dbg); end
        tick();
        checks++; if (dbg !== 3'd0 || menu !== 1'b1) begin errors++; $display("FAIL rej3_menu: state=%0d menu=%0b want 0/1", dbg, menu); end
    endtask

    task automatic test_done_priority();
        choice = 2'd1; mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        checks++; if (en !== 2'b01 || start !== 1'b1 || active !== 2'd1) begin errors++; $display("FAIL dp_load: en=%b start=%0b active=%0d want 01/1/1", en, start, active); end
        tick();
        quit = 1'b1;
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        checks++; if (dbg !== 3'd0 || en !== 2'b00 || menu !== 1'b1) begin errors++; $display("FAIL dp_done: state=%0d en=%b menu=%0b want 0/00/1", dbg, en, menu); end
        done = 1'b0;
        tick(); tick();
        checks++; if (dbg !== 3'd0 || en !== 2'b00) begin errors++; $display("FAIL dp_quit_menu: state=%0d en=%b want 0/00", dbg, en); end
        quit = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        choice = 2'd2; mode = 1'b1;
        tick();
        mode = 1'b0;
        tick(); tick();
        checks++; if (en !== 2'b10 || dbg !== 3'd5) begin errors++; $display("FAIL ar_run: en=%b state=%0d want 10/5", en, dbg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (en !== 2'b00 || menu !== 1'b1 || active !== 2'd0 || dbg !== 3'd0) begin errors++; $display("FAIL ar_async: en=%b menu=%0b active=%0d state=%0d want 00/1/0/0", en, menu, active, dbg); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        choice = 2'd1; mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        checks++; if (en !== 2'b01 || start !== 1'b1 || active !== 2'd1) begin errors++; $display("FAIL ar_reselect: en=%b start=%0b active=%0d want 01/1/1", en, start, active); end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (menu !== 1'b1 || en !== 2'b00) begin errors++; $display("FAIL ar_done: menu=%0b en=%b want 1/00", menu, en); end
    endtask

    task automatic test_wide();
        choice5 = 3'd5; mode5 = 1'b1;
        tick();
        checks++; if (active5 !== 3'd5) begin errors++; $display("FAIL w_latch: got %0d want 5", active5); end
        choice5 = 3'd2;
        tick();
        checks++; if (active5 !== 3'd5 || menu5 !== 1'b1) begin errors++; $display("FAIL w_arm_ignore: active=%0d menu=%0b want 5/1", active5, menu5); end
        mode5 = 1'b0;
        tick();
        checks++; if (en5 !== 5'b10000 || start5 !== 1'b1 || menu5 !== 1'b0) begin errors++; $display("FAIL w_load: en=%b start=%0b menu=%0b want 10000/1/0", en5, start5, menu5); end
        tick();
        checks++; if (en5 !== 5'b10000 || start5 !== 1'b0) begin errors++; $display("FAIL w_run: en=%b start=%0b want 10000/0", en5, start5); end
        done5 = 1'b1;
        tick();
        done5 = 1'b0;
        checks++; if (menu5 !== 1'b1 || en5 !== 5'b00000 || active5 !== 3'd5) begin errors++; $display("FAIL w_done: menu=%0b en=%b active=%0d want 1/00000/5", menu5, en5, active5); end
        choice5 = 3'd6; mode5 = 1'b1;
        tick();
        checks++; if (reject5 !== 1'b1 || en5 !== 5'b00000) begin errors++; $display("FAIL w_rej6: rej=%0b en=%b want 1/00000", reject5, en5); end
        mode5 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_select();
        test_quit();
        test_reject();
        test_done_priority();
        test_async_reset();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
